// File: rtl/ctrl_pkg.sv
// Opcode map, execute-command and branch encodings, and the control bundle
// shared by the decode stage and its combinational decoder.
package ctrl_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'b000001;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'b000011;
    localparam logic [OPC_W-1:0] OP_AND  = 6'b000101;
    localparam logic [OPC_W-1:0] OP_OR   = 6'b000110;
    localparam logic [OPC_W-1:0] OP_NOR  = 6'b000111;
    localparam logic [OPC_W-1:0] OP_XOR  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_SLA  = 6'b001001;
    localparam logic [OPC_W-1:0] OP_SLL  = 6'b001010;
    localparam logic [OPC_W-1:0] OP_SRA  = 6'b001011;
    localparam logic [OPC_W-1:0] OP_SRL  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'b100000;
    localparam logic [OPC_W-1:0] OP_SUBI = 6'b100001;
    localparam logic [OPC_W-1:0] OP_LD   = 6'b100100;
    localparam logic [OPC_W-1:0] OP_ST   = 6'b100101;
    localparam logic [OPC_W-1:0] OP_BEZ  = 6'b101000;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'b101001;
    localparam logic [OPC_W-1:0] OP_JMP  = 6'b101010;

    localparam logic [3:0] EXE_ADD = 4'b0000;
    localparam logic [3:0] EXE_SUB = 4'b0010;
    localparam logic [3:0] EXE_AND = 4'b0100;
    localparam logic [3:0] EXE_OR  = 4'b0101;
    localparam logic [3:0] EXE_NOR = 4'b0110;
    localparam logic [3:0] EXE_XOR = 4'b0111;
    localparam logic [3:0] EXE_SHL = 4'b1000;
    localparam logic [3:0] EXE_SRA = 4'b1001;
    localparam logic [3:0] EXE_SRL = 4'b1010;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef struct packed {
        logic [3:0] exec_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       is_imm;
        logic       single_src;
        logic [1:0] branch_type;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '{
        exec_cmd: EXE_ADD, mem_r_en: 1'b0, mem_w_en: 1'b0, wb_en: 1'b0,
        is_imm: 1'b0, single_src: 1'b0, branch_type: BR_NONE
    };

    function automatic ctrl_bundle_t make_ctrl(
        input logic [3:0] exec_cmd,
        input logic       mem_r_en,
        input logic       mem_w_en,
        input logic       wb_en,
        input logic       is_imm,
        input logic       single_src,
        input logic [1:0] branch_type
    );
        ctrl_bundle_t c;
        c.exec_cmd    = exec_cmd;
        c.mem_r_en    = mem_r_en;
        c.mem_w_en    = mem_w_en;
        c.wb_en       = wb_en;
        c.is_imm      = is_imm;
        c.single_src  = single_src;
        c.branch_type = branch_type;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, illegal flag and which
// source operands the instruction actually reads.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_bundle_t     ctrl,
    output logic             illegal,
    output logic             use_src1,
    output logic             use_src2
);

    always_comb begin
        // NOTE: every output is given a default first so no path through the case infers a latch.
        ctrl     = CTRL_NOP;
        illegal  = 1'b0;
        use_src1 = 1'b0;
        use_src2 = 1'b0;

        //                              exec     mr    mw    wb    imm   single br
        case (opcode)
            OP_NOP:  ctrl = CTRL_NOP;
            OP_ADD:  ctrl = make_ctrl(EXE_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE);
            OP_SUB:  ctrl = make_ctrl(EXE_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE);
            OP_AND:  ctrl = make_ctrl(EXE_AND, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE);
            OP_OR:   ctrl = make_ctrl(EXE_OR,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE);
            OP_NOR:  ctrl = make_ctrl(EXE_NOR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE);
            OP_XOR:  ctrl = make_ctrl(EXE_XOR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE);
            OP_SLA,
            OP_SLL:  ctrl = make_ctrl(EXE_SHL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE);
            OP_SRA:  ctrl = make_ctrl(EXE_SRA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE);
            OP_SRL:  ctrl = make_ctrl(EXE_SRL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE);
            OP_ADDI: ctrl = make_ctrl(EXE_ADD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, BR_NONE);
            OP_SUBI: ctrl = make_ctrl(EXE_SUB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, BR_NONE);
            OP_LD:   ctrl = make_ctrl(EXE_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, BR_NONE);
            OP_ST:   ctrl = make_ctrl(EXE_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BR_NONE);
            OP_BEZ:  ctrl = make_ctrl(EXE_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, BR_BEZ);
            OP_BNE:  ctrl = make_ctrl(EXE_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, BR_BNE);
            OP_JMP:  ctrl = make_ctrl(EXE_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, BR_JMP);
            default: illegal = 1'b1;
        endcase

        // JMP carries only an immediate; single-source ops leave src2 unread.
        use_src1 = !illegal && (opcode != OP_NOP) && (opcode != OP_JMP);
        use_src2 = !illegal && (opcode != OP_NOP) && !ctrl.single_src;
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered control decode stage with valid/ready toward fetch, RAW hazard
// stall against a shadow of in-flight destinations, branch flush and illegal count.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int HAZ_DEPTH  = 3,   // 1..8
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPC_W-1:0]      opcode,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [3:0]            exec_cmd,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic                  wb_en,
    output logic                  is_imm,
    output logic                  single_src,
    output logic [1:0]            branch_type,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  illegal,
    output logic [CNT_W-1:0]      illegal_cnt
);

    ctrl_bundle_t dec_ctrl;
    logic         dec_illegal;
    logic         use_src1;
    logic         use_src2;

    ctrl_decode u_decode (
        .opcode   (opcode),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .use_src1 (use_src1),
        .use_src2 (use_src2)
    );

    // Shadow of the last HAZ_DEPTH issue slots; entry 0 mirrors the output register.
    logic [HAZ_DEPTH-1:0]  sh_valid;
    logic [HAZ_DEPTH-1:0]  sh_wb;
    logic [REG_ADDR_W-1:0] sh_dest [HAZ_DEPTH];

    logic         hazard;
    logic         issue;
    ctrl_bundle_t out_ctrl;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sh_valid[i] && sh_wb[i]) begin
                if (use_src1 && (src1 != '0) && (src1 == sh_dest[i])) hazard = 1'b1;
                if (use_src2 && (src2 != '0) && (src2 == sh_dest[i])) hazard = 1'b1;
            end
        end
        hazard = hazard && in_valid;
    end

    // A flush consumes the input even when it is stalled.
    assign in_ready = rst_n && (!hazard || flush);
    assign issue    = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples values from before the edge.
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_NOP;
            out_dest  <= '0;
            illegal   <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_ctrl  <= dec_ctrl;
            out_dest  <= dest;
            illegal   <= dec_illegal;
        end else begin
            out_valid <= 1'b0;
            out_ctrl  <= CTRL_NOP;
            out_dest  <= '0;
            illegal   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_valid <= '0;
            sh_wb    <= '0;
        end else begin
            sh_valid[0] <= issue;
            sh_wb[0]    <= issue && dec_ctrl.wb_en;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                sh_valid[i] <= sh_valid[i-1];
                sh_wb[i]    <= sh_wb[i-1];
            end
        end
    end

    // NOTE: destination fields are left unreset; they are only ever read behind their valid bit.
    always_ff @(posedge clk) begin
        sh_dest[0] <= dest;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
            sh_dest[i] <= sh_dest[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (issue && dec_illegal && !(&illegal_cnt)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign exec_cmd    = out_ctrl.exec_cmd;
    assign mem_r_en    = out_ctrl.mem_r_en;
    assign mem_w_en    = out_ctrl.mem_w_en;
    assign wb_en       = out_ctrl.wb_en;
    assign is_imm      = out_ctrl.is_imm;
    assign single_src  = out_ctrl.single_src;
    assign branch_type = out_ctrl.branch_type;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: directed scenarios followed by random
// traffic, checked against a register-ready-time model of the stage.
module tb_ctrl_decode_stage;

    localparam int RW = 5;
    localparam int HD = 3;
    localparam int CW = 8;

    localparam logic [5:0] NOP = 6'b000000, ADD = 6'b000001, SUB = 6'b000011;
    localparam logic [5:0] ADDI = 6'b100000, BAD = 6'b111111;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, flush;
    logic [5:0]    opcode;
    logic [RW-1:0] src1, src2, dest;

    logic          in_ready, out_valid, mem_r_en, mem_w_en, wb_en, is_imm, single_src, illegal;
    logic [3:0]    exec_cmd;
    logic [1:0]    branch_type;
    logic [RW-1:0] out_dest;
    logic [CW-1:0] illegal_cnt;

    logic          b_in_ready, b_out_valid, b_mem_r_en, b_mem_w_en, b_wb_en, b_is_imm, b_single_src, b_illegal;
    logic [3:0]    b_exec_cmd;
    logic [1:0]    b_branch_type;
    logic [RW-1:0] b_out_dest;
    logic [1:0]    b_illegal_cnt;

    ctrl_decode_stage #(.REG_ADDR_W(RW), .HAZ_DEPTH(HD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .src1(src1), .src2(src2), .dest(dest), .flush(flush), .out_valid(out_valid),
        .exec_cmd(exec_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
        .is_imm(is_imm), .single_src(single_src), .branch_type(branch_type),
        .out_dest(out_dest), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    ctrl_decode_stage #(.REG_ADDR_W(RW), .HAZ_DEPTH(HD), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .opcode(opcode),
        .src1(src1), .src2(src2), .dest(dest), .flush(flush), .out_valid(b_out_valid),
        .exec_cmd(b_exec_cmd), .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en), .wb_en(b_wb_en),
        .is_imm(b_is_imm), .single_src(b_single_src), .branch_type(b_branch_type),
        .out_dest(b_out_dest), .illegal(b_illegal), .illegal_cnt(b_illegal_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: a register may be read at edge e only when e >= ready_at[reg].
    int            edge_no = 0;
    int            ready_at [1 << RW];
    logic [10:0]   exp_bundle;
    logic          exp_valid, exp_illegal, dest_chk;
    logic [RW-1:0] exp_dest;
    int            exp_cnt, exp_cnt_b;

    logic [5:0] legal_ops [17] = '{6'b000000, 6'b000001, 6'b000011, 6'b000101, 6'b000110,
                                   6'b000111, 6'b001000, 6'b001001, 6'b001010, 6'b001011,
                                   6'b001100, 6'b100000, 6'b100001, 6'b100100, 6'b100101,
                                   6'b101000, 6'b101001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bundle bits {exec[3:0], mem_r, mem_w, wb, imm, single, br[1:0]} from the opcode table.
    function automatic void ref_decode(input logic [5:0] op, output logic [10:0] b,
                                       output logic legal, output logic u1, output logic u2);
        legal = 1'b1;
        case (op)
            6'b000000: b = {4'b0000, 5'b00000, 2'b00};
            6'b000001: b = {4'b0000, 5'b00100, 2'b00};
            6'b000011: b = {4'b0010, 5'b00100, 2'b00};
            6'b000101: b = {4'b0100, 5'b00100, 2'b00};
            6'b000110: b = {4'b0101, 5'b00100, 2'b00};
            6'b000111: b = {4'b0110, 5'b00100, 2'b00};
            6'b001000: b = {4'b0111, 5'b00100, 2'b00};
            6'b001001: b = {4'b1000, 5'b00100, 2'b00};
            6'b001010: b = {4'b1000, 5'b00100, 2'b00};
            6'b001011: b = {4'b1001, 5'b00100, 2'b00};
            6'b001100: b = {4'b1010, 5'b00100, 2'b00};
            6'b100000: b = {4'b0000, 5'b00111, 2'b00};
            6'b100001: b = {4'b0010, 5'b00111, 2'b00};
            6'b100100: b = {4'b0000, 5'b10111, 2'b00};
            6'b100101: b = {4'b0000, 5'b01010, 2'b00};
            6'b101000: b = {4'b0000, 5'b00011, 2'b01};
            6'b101001: b = {4'b0000, 5'b00010, 2'b10};
            6'b101010: b = {4'b0000, 5'b00011, 2'b11};
            default: begin b = '0; legal = 1'b0; end
        endcase
        u1 = legal && (op != 6'b000000) && (op != 6'b101010);
        u2 = legal && (op != 6'b000000) && !b[2];
    endfunction

    function automatic logic model_hazard(input logic v, input logic [5:0] op,
                                          input logic [RW-1:0] s1, input logic [RW-1:0] s2);
        logic [10:0] b;
        logic lg, u1, u2;
        int up;
        ref_decode(op, b, lg, u1, u2);
        up = edge_no + 1;
        return v && ((u1 && s1 != 0 && up < ready_at[s1]) || (u2 && s2 != 0 && up < ready_at[s2]));
    endfunction

    task automatic cycle(input logic v, input logic [5:0] op, input logic [RW-1:0] s1,
                         input logic [RW-1:0] s2, input logic [RW-1:0] d, input logic fl,
                         input logic rn, output logic acc);
        logic rdy, lg, u1, u2;
        logic [10:0] b;
        in_valid = v; opcode = op; src1 = s1; src2 = s2; dest = d; flush = fl; rst_n = rn;
        @(negedge clk);
        rdy = rn && (!model_hazard(v, op, s1, s2) || fl);
        check("in_ready", 32'(in_ready), 32'(rdy));
        acc = v && rdy;
        @(posedge clk);
        edge_no++;
        ref_decode(op, b, lg, u1, u2);
        if (!rn) begin
            exp_valid = 1'b0; exp_bundle = '0; exp_illegal = 1'b0; exp_dest = '0; dest_chk = 1'b1;
            exp_cnt = 0; exp_cnt_b = 0;
            foreach (ready_at[r]) ready_at[r] = 0;
        end else if (acc && !fl) begin
            exp_valid = 1'b1; exp_bundle = b; exp_illegal = !lg; exp_dest = d; dest_chk = 1'b1;
            if (!lg) begin
                exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
                exp_cnt_b = (exp_cnt_b < 3) ? exp_cnt_b + 1 : 3;
            end
            if (b[4]) ready_at[d] = edge_no + HD + 1;
        end else begin
            exp_valid = 1'b0; exp_bundle = '0; exp_illegal = 1'b0; dest_chk = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("bundle", 32'({exec_cmd, mem_r_en, mem_w_en, wb_en, is_imm, single_src, branch_type}),
              32'(exp_bundle));
        check("illegal", 32'(illegal), 32'(exp_illegal));
        check("illegal_cnt", 32'(illegal_cnt), 32'(exp_cnt));
        check("illegal_cnt_w2", 32'(b_illegal_cnt), 32'(exp_cnt_b));
        if (dest_chk) check("out_dest", 32'(out_dest), 32'(exp_dest));
    endtask

    task automatic present(input logic [5:0] op, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                           input logic [RW-1:0] d, output int stalls);
        logic acc;
        stalls = 0;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            cycle(1'b1, op, s1, s2, d, 1'b0, 1'b1, acc);
            if (!acc) stalls++;
        end
        check("accept_bound", 32'(acc), 32'(1));
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, NOP, 0, 0, 0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        int   st;
        logic acc, v, fl, rn, have, held;
        logic [5:0] c_op;
        logic [RW-1:0] c_s1, c_s2, c_d;

        foreach (ready_at[r]) ready_at[r] = 0;
        exp_cnt = 0; exp_cnt_b = 0;

        // Reset, then independent back-to-back ops.
        cycle(1'b0, NOP, 0, 0, 0, 1'b0, 1'b0, acc);
        cycle(1'b1, ADD, 2, 3, 1, 1'b0, 1'b0, acc);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_cnt", 32'(illegal_cnt), 32'(0));
        present(ADD, 2, 3, 1, st);
        check("add_stall", 32'(st), 32'(0));
        check("add_exec", 32'(exec_cmd), 32'(4'b0000));
        present(SUB, 5, 6, 4, st);
        check("sub_stall", 32'(st), 32'(0));
        check("sub_exec", 32'(exec_cmd), 32'(4'b0010));
        idle(4);

        // RAW on r1 right behind its producer.
        present(ADD, 2, 3, 1, st);
        present(SUB, 1, 5, 4, st);
        check("raw_stalls", 32'(st), 32'(3));
        check("raw_issue", 32'(out_valid), 32'(1));
        idle(4);

        // r0 never hazards; an unused src2 field never hazards.
        present(ADD, 2, 3, 0, st);
        present(SUB, 0, 0, 4, st);
        check("r0_stalls", 32'(st), 32'(0));
        idle(4);
        present(ADD, 2, 4, 3, st);
        present(ADDI, 5, 3, 6, st);
        check("unused_src2_stalls", 32'(st), 32'(0));
        idle(4);

        // Flush while stalled drops the instruction.
        present(ADD, 2, 3, 1, st);
        cycle(1'b1, SUB, 1, 5, 4, 1'b0, 1'b1, acc);
        check("flush_pre_stall", 32'(acc), 32'(0));
        cycle(1'b1, SUB, 1, 5, 4, 1'b1, 1'b1, acc);
        check("flush_accept", 32'(acc), 32'(1));
        check("flush_bubble", 32'(out_valid), 32'(0));
        idle(4);

        // Illegal opcodes and counter saturation on the 2-bit instance.
        present(BAD, 1, 2, 3, st);
        check("ill_pulse", 32'(illegal), 32'(1));
        check("ill_cnt1", 32'(illegal_cnt), 32'(1));
        for (int i = 0; i < 4; i++) present(BAD, 1, 2, 3, st);
        check("ill_cnt5", 32'(illegal_cnt), 32'(5));
        check("ill_cnt_sat", 32'(b_illegal_cnt), 32'(3));
        idle(2);
        check("ill_pulse_gone", 32'(illegal), 32'(0));

        // Reset in the middle of a stall.
        present(ADD, 2, 3, 1, st);
        cycle(1'b1, SUB, 1, 5, 4, 1'b0, 1'b1, acc);
        cycle(1'b1, SUB, 1, 5, 4, 1'b0, 1'b0, acc);
        check("midrst_cnt", 32'(illegal_cnt), 32'(0));
        present(SUB, 1, 5, 4, st);
        check("post_rst_stalls", 32'(st), 32'(0));

        // Random traffic; fetch holds an instruction until it is taken.
        have = 1'b0; held = 1'b0;
        c_op = NOP; c_s1 = 0; c_s2 = 0; c_d = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!have) begin
                c_op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 16)]
                                                   : 6'($urandom());
                c_s1 = RW'($urandom_range(0, 3));
                c_s2 = RW'($urandom_range(0, 3));
                c_d  = RW'($urandom_range(0, 3));
                have = 1'b1;
            end
            v  = held ? 1'b1 : ($urandom_range(0, 9) < 8);
            fl = ($urandom_range(0, 15) == 0);
            rn = ($urandom_range(0, 63) != 0);
            cycle(v, c_op, c_s1, c_s2, c_d, fl, rn, acc);
            held = v && !acc;
            if (acc) have = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered, hazard-aware control decode stage that replaces the purely combinational opcode decoder between instruction fetch/ID and execute. It decodes the 6-bit opcode into the execute/memory/writeback control bundle, adds a valid/ready handshake toward fetch and a pipeline output register toward EX, and stalls on read-after-write hazards. Hazards are detected against a parametrised shadow of in-flight destination registers. It also accepts a branch flush, and flags and counts illegal opcodes.

## Interface
- `REG_ADDR_W`, default 5: register index width. Register 0 is hard-wired zero and never causes a hazard.
- `HAZ_DEPTH`, default 3: number of in-flight issued instructions checked for hazards (EX, MEM, WB). Legal range is 1 to 8.
- `CNT_W`, default 8: width of the illegal-opcode counter.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `opcode`  in  6  instruction opcode.
- `src1`, `src2`, `dest`  in  `REG_ADDR_W` each  register indices.
- `flush`  in  1  taken branch resolved in EX; kill the instruction at the input.
- `out_valid`  out  1  the output bundle holds a real instruction, not a bubble.
- `exec_cmd`  out  4; `mem_r_en`, `mem_w_en`, `wb_en`, `is_imm`, `single_src`  out  1 each; `branch_type`  out  2  registered control bundle.
- `out_dest`  out  `REG_ADDR_W`  registered destination index.
- `illegal`  out  1  one-cycle pulse, registered with the bundle.
- `illegal_cnt`  out  `CNT_W`  saturating count of accepted illegal opcodes.

## Operation
- Decode is combinational from `opcode` and gives the bundle values listed under Structure. An unknown opcode decodes to the NOP bundle with `illegal` set.
- Source use:
  - `src1` is used by every opcode except NOP, JMP and illegal opcodes.
  - `src2` is used when `single_src` is 0 and the opcode is not NOP or illegal. This covers the R-type ops, ST and BNE.
- Shadow: `HAZ_DEPTH` entries of {valid, wb_en, dest}. Entry 0 mirrors the output register. The shadow shifts every cycle and the oldest entry drops off.
- Hazard: `in_valid`, a used source that is non-zero, and a match with any shadow entry whose valid and wb_en are both 1.
- `in_ready` equals `!hazard || flush`, and is 0 while `rst_n` is 0.
- Issue happens when `in_valid && in_ready && !flush`. On issue, the output register and shadow entry 0 load the decoded bundle and `dest` with `out_valid` set to 1.
- A bubble is loaded in every other case: all bundle bits 0, `out_valid` 0, `illegal` 0.
- Flush consumes the input instruction: `in_ready` is 1 and the instruction is dropped. The flush does not alter older shadow entries.
- `illegal_cnt` increments by 1 on each issue with `illegal` set and saturates at all ones.
- Reset values, with `rst_n` low at a rising edge:
  - `out_valid`, the bundle, `out_dest` and `illegal` are all 0.
  - Every shadow entry is invalid.
  - `illegal_cnt` is 0.
  - A reset in the middle of a stall discards the stalled instruction. Fetch must re-present it.

## Timing
- Latency is 1 cycle from acceptance to the bundle appearing on the outputs.
- Throughput is 1 instruction per cycle with no hazards.
- With the default `HAZ_DEPTH` of 3, a dependent instruction that immediately follows its producer stalls for 3 cycles and is issued on the 4th cycle after the producer.
- `in_valid` and the instruction fields must stay stable while `in_ready` is 0. The stage does not check this.
- When `flush` and `hazard` are both high, the flush wins.

## Structure
- Package `ctrl_pkg` holds the opcode localparams and the exec_cmd and branch_type constants. Each opcode line below gives the opcode, then exec_cmd, then the control bits that are set.
  - NOP 000000: 0000, none.
  - ADD 000001: 0000, wb.
  - SUB 000011: 0010, wb.
  - AND 000101: 0100, wb.
  - OR 000110: 0101, wb.
  - NOR 000111: 0110, wb.
  - XOR 001000: 0111, wb.
  - SLA 001001 and SLL 001010: 1000, wb.
  - SRA 001011: 1001, wb.
  - SRL 001100: 1010, wb.
  - ADDI 100000: 0000, imm, wb, single.
  - SUBI 100001: 0010, imm, wb, single.
  - LD 100100: 0000, imm, mem_r, wb, single.
  - ST 100101: 0000, imm, mem_w.
  - BEZ 101000: 0000, imm, single, branch_type 01.
  - BNE 101001: 0000, imm, branch_type 10.
  - JMP 101010: 0000, imm, single, branch_type 11.
- One combinational sub-module, `ctrl_decode`, covers opcode-to-bundle decode plus `illegal`, `use_src1` and `use_src2`. Hazard checking, the shadow, the output register and the counter live in the top module.

## Test plan
- Reset then back-to-back independent ops: after reset all outputs are 0. ADD r1,r2,r3 followed by SUB r4,r5,r6 issue on consecutive cycles with `exec_cmd` 0000 then 0010.
- RAW stall: ADD with dest r1, then SUB with src1 r1. `in_ready` stays 0 for 3 cycles, the output shows 3 bubbles, and SUB issues on the 4th cycle.
- R0 and unused-source exemption: ADD with dest r0 then a consumer reading r0 gives no stall. ADD with dest r3 then ADDI with src2 field r3 gives no stall.
- Flush during stall: with SUB stalled on r1, assert `flush` for 1 cycle. `in_ready` is 1, a bubble is issued and SUB is never issued.
- Illegal opcodes: 6'b111111 issues a NOP bundle with `illegal` 1 and `illegal_cnt` 1. With `CNT_W` 2, five illegal opcodes leave `illegal_cnt` at 3.
- Reset mid-stall: drop `rst_n` while stalled. The next edge clears everything, and a re-presented SUB issues without a stall.
